leve1_axir_arb: RTL and testbench

Two-to-one AXI read arbiter sharing the single instruction/data memory read port of the LEVE1 core between the IF stage (instruction fetch) and the EX stage (load unit). It sits between those two AXIR initiators and the external AXIR target. It allows one outstanding transaction at a time, arbitrates round-robin on address-channel requests, and routes read-data beats back to the granted requester until RLAST.

---
 rtl/leve1_axir_arb.sv | 131 +++++++++++++
 tb/tb_leve1_axir_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leve1_axir_arb.sv
// Two-to-one AXI read arbiter for the LEVE1 core. It shares one memory read
// port between instruction fetch (RI) and the load unit (RD), with one
// outstanding transaction and round-robin arbitration on address requests.
module leve1_axir_arb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned DLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // instruction requester
    input  logic            ri_arvalid_i,
    output logic            ri_arready_o,
    input  logic [XLEN-1:0] ri_araddr_i,
    input  logic [7:0]      ri_arlen_i,
    output logic            ri_rvalid_o,
    input  logic            ri_rready_i,
    output logic [DLEN-1:0] ri_rdata_o,
    output logic [1:0]      ri_rresp_o,
    output logic            ri_rlast_o,
    // data requester
    input  logic            rd_arvalid_i,
    output logic            rd_arready_o,
    input  logic [XLEN-1:0] rd_araddr_i,
    input  logic [7:0]      rd_arlen_i,
    output logic            rd_rvalid_o,
    input  logic            rd_rready_i,
    output logic [DLEN-1:0] rd_rdata_o,
    output logic [1:0]      rd_rresp_o,
    output logic            rd_rlast_o,
    // shared memory port
    output logic            rm_arvalid_o,
    input  logic            rm_arready_i,
    output logic [XLEN-1:0] rm_araddr_o,
    output logic [7:0]      rm_arlen_o,
    input  logic            rm_rvalid_i,
    output logic            rm_rready_o,
    input  logic [DLEN-1:0] rm_rdata_i,
    input  logic [1:0]      rm_rresp_i,
    input  logic            rm_rlast_i,
    // debug
    output logic            busy_o,
    output logic            gnt_d_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_q, last_d;      // 0 = RI, 1 = RD
    logic [XLEN-1:0] addr_q, addr_d;
    logic [7:0]      len_q, len_d;

    logic win;      // requester that would be granted this cycle
    logic grant;
    logic in_data;

    // Arbitration: a tie goes to whoever was not granted last time.
    // Reset is folded in so no ARREADY can leak out while reset is held.
    always_comb begin
        win   = (ri_arvalid_i && rd_arvalid_i) ? ~last_q : rd_arvalid_i;
        grant = rst_ni && (state_q == StIdle) && (ri_arvalid_i || rd_arvalid_i);
    end

    // Next-state logic for the transaction FSM and the latched request.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StAddr;
                    last_d  = win;
                    addr_d  = win ? rd_araddr_i : ri_araddr_i;
                    len_d   = win ? rd_arlen_i : ri_arlen_i;
                end
            end
            StAddr: begin
                if (rm_arready_i) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (rm_rvalid_i && rm_rready_o && rm_rlast_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    // Output routing: AR toward memory from registers, R beats passed through.
    always_comb begin
        in_data      = (state_q == StData);
        ri_arready_o = grant && !win;
        rd_arready_o = grant && win;
        rm_arvalid_o = (state_q == StAddr);
        rm_araddr_o  = addr_q;
        rm_arlen_o   = len_q;
        ri_rvalid_o  = in_data && !last_q && rm_rvalid_i;
        rd_rvalid_o  = in_data && last_q && rm_rvalid_i;
        rm_rready_o  = in_data && (last_q ? rd_rready_i : ri_rready_i);
        // Payload is shared; only RVALID qualifies it.
        ri_rdata_o   = rm_rdata_i;
        ri_rresp_o   = rm_rresp_i;
        ri_rlast_o   = rm_rlast_i;
        rd_rdata_o   = rm_rdata_i;
        rd_rresp_o   = rm_rresp_i;
        rd_rlast_o   = rm_rlast_i;
        busy_o       = (state_q != StIdle);
        gnt_d_o      = last_q;
    end

endmodule

// File: tb/tb_leve1_axir_arb.sv
// Bench for leve1_axir_arb: directed timing scenarios followed by randomized
// traffic from two requesters and a memory responder, checked by a scoreboard.
module tb_leve1_axir_arb;

    localparam int RI  = 0;
    localparam int RD  = 1;
    localparam int NTX = 40;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  l;
    } ar_t;

    typedef struct packed {
        logic        id;
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr [2];
    logic [7:0]  s_arlen  [2];
    logic [31:0] s_rdata  [2];
    logic [1:0]  s_rresp  [2];
    logic        rm_arvalid, rm_arready, rm_rvalid, rm_rready, rm_rlast;
    logic [31:0] rm_araddr, rm_rdata;
    logic [7:0]  rm_arlen;
    logic [1:0]  rm_rresp;
    logic        busy, gnt_d;

    int    checks = 0;
    int    failures = 0;
    int    agents_done = 0;
    bit    done = 1'b0;
    logic  tb_last;
    ar_t   ar_q[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;

    leve1_axir_arb #(.XLEN(32), .DLEN(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .ri_arvalid_i(s_arvalid[RI]),
        .ri_arready_o(s_arready[RI]),
        .ri_araddr_i (s_araddr[RI]),
        .ri_arlen_i  (s_arlen[RI]),
        .ri_rvalid_o (s_rvalid[RI]),
        .ri_rready_i (s_rready[RI]),
        .ri_rdata_o  (s_rdata[RI]),
        .ri_rresp_o  (s_rresp[RI]),
        .ri_rlast_o  (s_rlast[RI]),
        .rd_arvalid_i(s_arvalid[RD]),
        .rd_arready_o(s_arready[RD]),
        .rd_araddr_i (s_araddr[RD]),
        .rd_arlen_i  (s_arlen[RD]),
        .rd_rvalid_o (s_rvalid[RD]),
        .rd_rready_i (s_rready[RD]),
        .rd_rdata_o  (s_rdata[RD]),
        .rd_rresp_o  (s_rresp[RD]),
        .rd_rlast_o  (s_rlast[RD]),
        .rm_arvalid_o(rm_arvalid),
        .rm_arready_i(rm_arready),
        .rm_araddr_o (rm_araddr),
        .rm_arlen_o  (rm_arlen),
        .rm_rvalid_i (rm_rvalid),
        .rm_rready_o (rm_rready),
        .rm_rdata_i  (rm_rdata),
        .rm_rresp_i  (rm_rresp),
        .rm_rlast_i  (rm_rlast),
        .busy_o      (busy),
        .gnt_d_o     (gnt_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents are a pure function of address and beat index.
    function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
        return a ^ (32'h0101_0101 * b) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] a, input int b);
        logic [31:0] s;
        s = a + b;
        return s[5:4];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_arvalid  = '0;
        s_rready   = '0;
        s_araddr[RI] = '0; s_araddr[RD] = '0;
        s_arlen[RI]  = '0; s_arlen[RD]  = '0;
        rm_arready = 1'b0;
        rm_rvalid  = 1'b0;
        rm_rdata   = '0;
        rm_rresp   = '0;
        rm_rlast   = 1'b0;
    endtask

    task automatic req_agent(input int id);
        beat_t bt;
        ar_t   ar;
        int    cnt;
        for (int t = 0; t < NTX; t++) begin
            repeat (($urandom_range(0, 3) == 0) ? 2 : 0) step();
            s_arvalid[id] = 1'b1;
            s_araddr[id]  = $urandom & 32'hFFFF_FFFC;
            s_arlen[id]   = 8'($urandom_range(0, 3));
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!s_arready[id] && cnt < 2000);
            if (s_arready[id]) begin
                ar.a = s_araddr[id];
                ar.l = s_arlen[id];
                ar_q.push_back(ar);
                for (int b = 0; b <= int'(s_arlen[id]); b++) begin
                    bt.id = id[0];
                    bt.d  = beat_data(s_araddr[id], b);
                    bt.r  = beat_resp(s_araddr[id], b);
                    bt.l  = (b == int'(s_arlen[id]));
                    exp_q.push_back(bt);
                end
            end else begin
                chk("ar_grant_timeout", 32'(s_arready[id]), 32'd1);
            end
            step();
            s_arvalid[id] = 1'b0;
        end
        agents_done++;
    endtask

    task automatic mem_agent();
        bit          busy_m = 1'b0;
        bit          taken = 1'b0;
        logic [31:0] m_addr = '0;
        int          m_len = 0;
        int          m_beat = 0;
        ar_t         ar;
        while (!done) begin
            step();
            rm_arready   = ($urandom_range(0, 2) != 0);
            s_rready[RI] = ($urandom_range(0, 3) != 0);
            s_rready[RD] = ($urandom_range(0, 3) != 0);
            if (!busy_m) begin
                rm_rvalid = 1'b0;
            end else if (taken || !rm_rvalid) begin
                rm_rvalid = ($urandom_range(0, 2) != 0);
            end
            rm_rdata = beat_data(m_addr, m_beat);
            rm_rresp = beat_resp(m_addr, m_beat);
            rm_rlast = (m_beat == m_len);
            taken = 1'b0;
            @(negedge clk);
            if (rm_arvalid && rm_arready) begin
                if (ar_q.size() == 0) begin
                    chk("rm_ar_unexpected", 32'd1, 32'd0);
                end else begin
                    ar = ar_q.pop_front();
                    chk("rm_araddr", rm_araddr, ar.a);
                    chk("rm_arlen", 32'(rm_arlen), 32'(ar.l));
                end
                busy_m = 1'b1;
                m_addr = rm_araddr;
                m_len  = int'(rm_arlen);
                m_beat = 0;
            end
            if (rm_rvalid && rm_rready) begin
                if (m_beat == m_len) busy_m = 1'b0;
                m_beat++;
                taken = 1'b1;
            end
        end
    endtask

    task automatic monitor();
        logic  exp_w;
        beat_t bt;
        while (!done) begin
            @(negedge clk);
            if (s_arready != 2'b00) begin
                exp_w = (s_arvalid == 2'b11) ? ~tb_last : s_arvalid[RD];
                chk("rr_grant", 32'(s_arready), exp_w ? 32'd2 : 32'd1);
                tb_last = exp_w;
            end
            for (int id = 0; id < 2; id++) begin
                if (s_rvalid[id]) begin
                    chk("rvalid_owner", 32'(exp_q.size() != 0 && exp_q[0].id == id[0]), 32'd1);
                    if (s_rready[id] && exp_q.size() != 0 && exp_q[0].id == id[0]) begin
                        bt = exp_q.pop_front();
                        chk("rdata", s_rdata[id], bt.d);
                        chk("rresp", 32'(s_rresp[id]), 32'(bt.r));
                        chk("rlast", 32'(s_rlast[id]), 32'(bt.l));
                    end
                end
            end
        end
    endtask

    initial begin
        int cyc;
        rst_ni = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt_d), 32'd1);
        chk("rst_rm_arvalid", 32'(rm_arvalid), 32'd0);
        chk("rst_rm_araddr", rm_araddr, 32'd0);
        chk("rst_rm_rready", 32'(rm_rready), 32'd0);
        step();
        rst_ni = 1'b1;

        // Single instruction fetch, cycle-exact.
        step();
        s_arvalid[RI] = 1'b1; s_araddr[RI] = 32'h0000_0100; s_arlen[RI] = 8'd0;
        rm_arready = 1'b1; s_rready[RI] = 1'b1;
        @(negedge clk);
        chk("fetch_c0_arready", 32'(s_arready), 32'd1);
        step();
        s_arvalid[RI] = 1'b0;
        @(negedge clk);
        chk("fetch_c1_arvalid", 32'(rm_arvalid), 32'd1);
        chk("fetch_c1_araddr", rm_araddr, 32'h100);
        chk("fetch_c1_gnt", 32'(gnt_d), 32'd0);
        step();
        rm_rvalid = 1'b1; rm_rdata = 32'h13; rm_rlast = 1'b1;
        @(negedge clk);
        chk("fetch_c2_rvalid", 32'(s_rvalid), 32'd1);
        chk("fetch_c2_rdata", s_rdata[RI], 32'h13);
        chk("fetch_c2_rm_rready", 32'(rm_rready), 32'd1);
        step();
        rm_rvalid = 1'b0; rm_rlast = 1'b0;
        @(negedge clk);
        chk("fetch_c3_idle", 32'(busy), 32'd0);

        // Address stall: RD granted, RM.ARREADY low for 5 cycles.
        step();
        s_arvalid[RD] = 1'b1; s_araddr[RD] = 32'h8000_0000; rm_arready = 1'b0;
        @(negedge clk);
        chk("stall_grant", 32'(s_arready), 32'd2);
        step();
        s_arvalid[RD] = 1'b0;
        s_arvalid[RI] = 1'b1; s_araddr[RI] = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_arvalid", 32'(rm_arvalid), 32'd1);
            chk("stall_araddr", rm_araddr, 32'h8000_0000);
            chk("stall_ri_arready", 32'(s_arready[RI]), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            step();
        end
        rm_arready = 1'b1;
        step();
        rm_arready = 1'b0; s_arvalid[RI] = 1'b0;
        rm_rvalid = 1'b1; rm_rdata = 32'hA0; rm_rlast = 1'b1; s_rready[RD] = 1'b1;
        @(negedge clk);
        chk("stall_beat_owner", 32'(s_rvalid), 32'd2);
        chk("stall_gnt", 32'(gnt_d), 32'd1);
        step();
        rm_rvalid = 1'b0; rm_rlast = 1'b0;

        // Burst of 4 with backpressure on beat 2.
        s_arvalid[RD] = 1'b1; s_araddr[RD] = 32'h0000_0300; s_arlen[RD] = 8'd3;
        rm_arready = 1'b1;
        @(negedge clk);
        chk("burst_grant", 32'(s_arready), 32'd2);
        step();
        s_arvalid[RD] = 1'b0;
        step();
        rm_arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rm_rvalid = 1'b1; rm_rdata = 32'hA0 + b; rm_rlast = (b == 3);
            if (b == 2) begin
                s_rready[RD] = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("burst_bp_rm_rready", 32'(rm_rready), 32'd0);
                    step();
                end
                s_rready[RD] = 1'b1;
            end
            @(negedge clk);
            chk("burst_rdata", s_rdata[RD], 32'hA0 + b);
            chk("burst_busy", 32'(busy), 32'd1);
            step();
        end
        rm_rvalid = 1'b0; rm_rlast = 1'b0;
        @(negedge clk);
        chk("burst_idle", 32'(busy), 32'd0);

        // Reset during beat 1 of a 4-beat RI burst.
        step();
        s_arvalid[RI] = 1'b1; s_araddr[RI] = 32'h0000_0400; s_arlen[RI] = 8'd3;
        rm_arready = 1'b1; s_rready[RI] = 1'b1;
        step();
        s_arvalid[RI] = 1'b0;
        step();
        rm_arready = 1'b0; rm_rvalid = 1'b1; rm_rdata = 32'hB0;
        step();
        rm_rdata = 32'hB1;
        s_arvalid[RI] = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_rvalid", 32'(s_rvalid), 32'd0);
        chk("arst_arready", 32'(s_arready), 32'd0);
        chk("arst_rm_rready", 32'(rm_rready), 32'd0);
        chk("arst_rm_arvalid", 32'(rm_arvalid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_gnt", 32'(gnt_d), 32'd1);
        rm_rvalid = 1'b0;
        step();
        rst_ni = 1'b1; s_arlen[RI] = 8'd0; rm_arready = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(s_arready), 32'd1);
        step();
        s_arvalid[RI] = 1'b0;
        @(negedge clk);
        chk("post_rst_araddr", rm_araddr, 32'h400);
        step();
        rm_arready = 1'b0; rm_rvalid = 1'b1; rm_rdata = 32'hC0; rm_rlast = 1'b1;
        @(negedge clk);
        chk("post_rst_rdata", s_rdata[RI], 32'hC0);
        chk("post_rst_owner", 32'(s_rvalid), 32'd1);
        step();
        clear_inputs();
        tb_last = 1'b0;

        // Randomized traffic.
        fork
            req_agent(RI);
            req_agent(RD);
            mem_agent();
            monitor();
        join_none
        cyc = 0;
        while ((agents_done < 2 || exp_q.size() != 0) && cyc < 40000) begin
            @(posedge clk);
            cyc++;
        end
        chk("drain_done", 32'(agents_done == 2 && exp_q.size() == 0), 32'd1);
        chk("ar_queue_empty", 32'(ar_q.size()), 32'd0);
        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
